mult4_acc: RTL and testbench
============================

# mult4_acc

Streaming multiply-accumulate front end for the 4x4 combinational multiplier `Multi4`. It accepts 4-bit operand pairs over a valid/ready handshake and registers them into `Multi4`'s a0..a3/b0..b3 inputs. It registers the 8-bit product from m0..m7 and sums FRAME_LEN products into one result, which it presents on a valid/ready output. It sits directly upstream of `Multi4` and consumes its product, wrapping the bare combinational array in a pipelined, flow-controlled stage.

## Interface
- FRAME_LEN, 4, number of products summed per result; legal range 1..255.
- ACC_W, 12, accumulator/result width; minimum 8.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous flush of the frame in progress; highest priority.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair this cycle.
- in_a  in  4  multiplicand, unsigned; bit i drives Multi4 input a_i.
- in_b  in  4  multiplier, unsigned; bit i drives Multi4 input b_i.
- out_valid  out  1  frame result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  ACC_W  frame sum of products.
- out_ovf  out  1  the sum exceeded 2^ACC_W-1 during this frame.

## Operation
- Pipeline stages:
  - S1: operand register op_a/op_b plus op_v, feeding one `Multi4` instance.
  - S2: product register prod[7:0] plus prod_v.
  - S3: accumulator (acc).
- Accept rule: a pair is taken when in_valid && in_ready at a rising edge.
- Issue counter `issued` (8 bits) counts accepted pairs; `added` counts products summed into acc.
- FSM states and transitions:
  - ACC: in_ready = (issued < FRAME_LEN). Move to DRAIN when the FRAME_LEN-th pair is accepted.
  - DRAIN: in_ready = 0. Wait for the remaining products. Move to DONE on the edge where the FRAME_LEN-th product is added.
  - DONE: in_ready = 0, out_valid = 1. On out_valid && out_ready: acc, out_ovf, issued and added are cleared, and the state returns to ACC.
- When FRAME_LEN = 1, accepting the pair moves ACC directly to DRAIN.
- Arithmetic: products are zero-extended to ACC_W + 1 bits for overflow detection. out_sum = acc.
- Overflow is sticky within a frame; its behaviour depends on the configuration macro.
- out_sum and out_ovf stay stable while out_valid is high and out_ready is low.
- in_valid while in_ready = 0 is ignored; in_a/in_b are not sampled.
- clr = 1 at an edge:
  - all valid bits, counters, acc and out_ovf go to 0, and the state goes to ACC;
  - an operand presented that cycle is dropped;
  - a pending result is discarded even if out_ready is high.
- Async reset with rst_n low:
  - state = ACC, all registers 0;
  - out_valid = 0, out_sum = 0, out_ovf = 0;
  - in_ready is forced to 0 while rst_n is low and reads 1 from the first cycle after release.
- Reset mid-frame discards all in-flight data.

## Timing
- Throughput within a frame: one pair per cycle.
- Latency, for the last pair of a frame accepted at edge E:
  - prod registered at E+1;
  - acc updated and out_valid = 1 after edge E+2.
- Earliest next-frame accept: the edge after the output handshake edge, since in_ready rises combinationally once the state returns to ACC.
- No combinational path from in_valid to in_ready or from out_ready to out_valid.
- Input bubbles stall only S1; products already in flight keep draining.

## Configuration
- MULT4_ACC_SAT_EN defined (saturating mode):
  - on overflow, acc clamps to 2^ACC_W-1 and stays there for the rest of the frame;
  - out_ovf = 1.
- MULT4_ACC_SAT_EN undefined (wrap mode):
  - acc wraps modulo 2^ACC_W;
  - out_ovf = 1 if any addition in the frame carried out of bit ACC_W-1.

## Test plan
- Basic frame: defaults, pairs (3,5),(15,15),(0,9),(7,2) on consecutive cycles -> out_sum = 254, out_ovf = 0, out_valid high after edge E+2 of the last accept.
- Backpressure: repeat the basic frame with out_ready low for 5 cycles -> out_sum holds 254, in_ready = 0 throughout; after the handshake edge, in_ready = 1 the next cycle and acc = 0.
- Bubbles: same pairs with in_valid low 1-3 cycles between them -> out_sum = 254, single out_valid pulse per frame.
- Overflow: ACC_W = 8, FRAME_LEN = 2, pairs (15,15),(15,15) -> wrap mode: out_sum = 194, out_ovf = 1; MULT4_ACC_SAT_EN: out_sum = 255, out_ovf = 1.
- clr mid-frame: accept (15,15),(15,15), assert clr for one cycle, then run the basic frame -> out_sum = 254; no result is emitted for the flushed pairs.
- Reset mid-frame: assert rst_n low during DRAIN -> out_valid/out_sum/out_ovf = 0 immediately and in_ready = 0 while low; after release, the basic frame yields 254.

Source files
------------

// File: rtl/mult4_acc.sv
// Streaming multiply-accumulate front end around the 4x4 combinational Multi4 array.
// Define MULT4_ACC_SAT_EN for a saturating accumulator; by default the sum wraps.

module Multi4 (
   input  logic a0,
   input  logic a1,
   input  logic a2,
   input  logic a3,
   input  logic b0,
   input  logic b1,
   input  logic b2,
   input  logic b3,
   output logic m0,
   output logic m1,
   output logic m2,
   output logic m3,
   output logic m4,
   output logic m5,
   output logic m6,
   output logic m7
);
   logic [7:0] a_x, b_x, m;

   assign a_x = {4'b0000, a3, a2, a1, a0};
   assign b_x = {4'b0000, b3, b2, b1, b0};
   assign m   = a_x * b_x;
   assign {m7, m6, m5, m4, m3, m2, m1, m0} = m;
endmodule

module mult4_acc #(
   parameter int unsigned FRAME_LEN = 4,
   parameter int unsigned ACC_W     = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_a,
   input  logic [3:0]       in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic             out_ovf
);
   typedef enum logic [1:0] {ACC, DRAIN, DONE} state_t;

   localparam logic [7:0] LAST = 8'(FRAME_LEN - 1);

   state_t           state;
   logic [3:0]       op_a, op_b;
   logic             op_v;
   logic [7:0]       mult, prod;
   logic             prod_v;
   logic [7:0]       issued, added;
   logic [ACC_W-1:0] acc, acc_nxt;
   logic             ovf, ovf_nxt;
   logic [ACC_W:0]   sum_ext;
   logic             take;

   // in_ready is held low during reset so nothing is taken while rst_n is low
   assign in_ready = rst_n && (state == ACC) && (issued <= LAST);
   assign take     = in_ready && in_valid && !clr;
   assign out_sum  = acc;
   assign out_ovf  = ovf;

   Multi4 u_mul (
      .a0(op_a[0]), .a1(op_a[1]), .a2(op_a[2]), .a3(op_a[3]),
      .b0(op_b[0]), .b1(op_b[1]), .b2(op_b[2]), .b3(op_b[3]),
      .m0(mult[0]), .m1(mult[1]), .m2(mult[2]), .m3(mult[3]),
      .m4(mult[4]), .m5(mult[5]), .m6(mult[6]), .m7(mult[7])
   );

   assign sum_ext = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, prod};

   always_comb begin
      acc_nxt = sum_ext[ACC_W-1:0];
      ovf_nxt = ovf | sum_ext[ACC_W];
`ifdef MULT4_ACC_SAT_EN
      if (ovf_nxt) acc_nxt = '1;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a   <= '0;
         op_b   <= '0;
         op_v   <= 1'b0;
         prod   <= '0;
         prod_v <= 1'b0;
      end else if (clr) begin
         op_v   <= 1'b0;
         prod_v <= 1'b0;
      end else begin
         op_v   <= take;
         prod_v <= op_v;
         if (take) begin
            op_a <= in_a;
            op_b <= in_b;
         end
         if (op_v) prod <= mult;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ACC;
         issued    <= '0;
         added     <= '0;
         acc       <= '0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end else if (clr) begin
         state     <= ACC;
         issued    <= '0;
         added     <= '0;
         acc       <= '0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         if (take) issued <= issued + 8'd1;
         if (prod_v) begin
            acc   <= acc_nxt;
            ovf   <= ovf_nxt;
            added <= added + 8'd1;
         end
         unique case (state)
            ACC:   if (take && issued == LAST) state <= DRAIN;
            DRAIN: if (prod_v && added == LAST) begin
               state     <= DONE;
               out_valid <= 1'b1;
            end
            DONE:  if (out_ready) begin
               state     <= ACC;
               out_valid <= 1'b0;
               issued    <= '0;
               added     <= '0;
               acc       <= '0;
               ovf       <= 1'b0;
            end
            default: state <= ACC;
         endcase
      end
   end
endmodule

// File: tb/tb_mult4_acc.sv
// Bench for mult4_acc: default instance plus an 8-bit, 2-product instance for overflow,
// each checked every cycle against a frame-level arithmetic model.

module tb_mult4_acc;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr[2]  = '{1'b0, 1'b0};
   logic        iv[2]   = '{1'b0, 1'b0};
   logic        ordy[2] = '{1'b0, 1'b0};
   logic [3:0]  ia[2]   = '{4'd0, 4'd0};
   logic [3:0]  ib[2]   = '{4'd0, 4'd0};
   logic        rdy0, ov0, ovf0, rdy1, ov1, ovf1;
   logic [11:0] sum0;
   logic [7:0]  sum1;

   int total = 0;
   int bad   = 0;

   // model state: products of the current frame and the edge index each pair was taken at
   int fl[2] = '{4, 2};
   int aw[2] = '{12, 8};
   int pr[2][256];
   int eg[2][256];
   int cnt[2] = '{0, 0};
   int now = 0;

   always #5 clk = ~clk;

   mult4_acc dut (
      .clk(clk), .rst_n(rst_n), .clr(clr[0]), .in_valid(iv[0]), .in_ready(rdy0),
      .in_a(ia[0]), .in_b(ib[0]), .out_valid(ov0), .out_ready(ordy[0]),
      .out_sum(sum0), .out_ovf(ovf0)
   );

   mult4_acc #(.FRAME_LEN(2), .ACC_W(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .clr(clr[1]), .in_valid(iv[1]), .in_ready(rdy1),
      .in_a(ia[1]), .in_b(ib[1]), .out_valid(ov1), .out_ready(ordy[1]),
      .out_sum(sum1), .out_ovf(ovf1)
   );

   // A product is in the sum two edges after its pair was taken; the result is valid once
   // all pairs of the frame are in.
   function automatic void expect_out(input int k, output bit rdy, output bit ov,
                                      output int sum, output bit ovf);
      int full = 0;
      int mx = (1 << aw[k]) - 1;
      rdy = 0; ov = 0; sum = 0; ovf = 0;
      if (rst_n !== 1'b1) return;
      for (int i = 0; i < cnt[k]; i++)
         if (eg[k][i] <= now - 2) full += pr[k][i];
      rdy = cnt[k] < fl[k];
      ov  = (cnt[k] == fl[k]) && (eg[k][cnt[k] - 1] <= now - 2);
      ovf = full > mx;
`ifdef MULT4_ACC_SAT_EN
      sum = ovf ? mx : full;
`else
      sum = full & mx;
`endif
   endfunction

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      bit r, v, f;
      int s;
      for (int k = 0; k < 2; k++) begin
         expect_out(k, r, v, s, f);
         if (rst_n !== 1'b1 || clr[k] || (v && ordy[k])) cnt[k] = 0;
         else if (iv[k] && r) begin
            pr[k][cnt[k]] = int'(ia[k]) * int'(ib[k]);
            eg[k][cnt[k]] = now + 1;
            cnt[k]++;
         end
      end
      now++;
   end

   always @(negedge clk) begin
      bit r, v, f;
      int s;
      for (int k = 0; k < 2; k++) begin
         expect_out(k, r, v, s, f);
         chk($sformatf("in_ready%0d", k), (k == 0) ? rdy0 : rdy1, r);
         chk($sformatf("out_valid%0d", k), (k == 0) ? ov0 : ov1, v);
         chk($sformatf("out_sum%0d", k), (k == 0) ? longint'(sum0) : longint'(sum1), s);
         chk($sformatf("out_ovf%0d", k), (k == 0) ? ovf0 : ovf1, f);
      end
   end

   int at[4] = '{3, 15, 0, 7};
   int bt[4] = '{5, 15, 9, 2};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic frame0(input int gap_max);
      for (int i = 0; i < 4; i++) begin
         iv[0] = 1'b1;
         ia[0] = 4'(at[i]);
         ib[0] = 4'(bt[i]);
         tick();
         iv[0] = 1'b0;
         if (gap_max > 0 && i < 3) repeat ($urandom_range(gap_max, 1)) tick();
      end
   endtask

   initial begin
      int pulses, seen;
      repeat (3) tick();
      chk("rst_ready", rdy0, 0);
      chk("rst_valid", ov0, 0);
      chk("rst_sum", sum0, 0);
      rst_n = 1'b1;
      #1;
      chk("post_rst_ready", rdy0, 1);
      tick();

      // basic frame with exact latency, then backpressure
      frame0(0);
      chk("lat_e0", ov0, 0);
      tick();
      chk("lat_e1", ov0, 0);
      tick();
      chk("lat_e2_valid", ov0, 1);
      chk("basic_sum", sum0, 254);
      chk("basic_ovf", ovf0, 0);
      repeat (5) begin
         chk("bp_sum", sum0, 254);
         chk("bp_ready", rdy0, 0);
         chk("bp_valid", ov0, 1);
         tick();
      end
      ordy[0] = 1'b1;
      tick();
      ordy[0] = 1'b0;
      chk("hs_ready", rdy0, 1);
      chk("hs_acc", sum0, 0);
      chk("hs_valid", ov0, 0);

      // bubbles
      ordy[0] = 1'b1;
      frame0(3);
      pulses = 0;
      seen = 0;
      repeat (12) begin
         if (ov0) begin
            pulses++;
            seen = sum0;
         end
         tick();
      end
      ordy[0] = 1'b0;
      chk("bubble_pulses", pulses, 1);
      chk("bubble_sum", seen, 254);

      // overflow on the 8-bit instance
      iv[1] = 1'b1; ia[1] = 4'd15; ib[1] = 4'd15;
      tick();
      tick();
      iv[1] = 1'b0;
      tick();
      tick();
      chk("ovf_valid", ov1, 1);
`ifdef MULT4_ACC_SAT_EN
      chk("ovf_sum", sum1, 255);
`else
      chk("ovf_sum", sum1, 194);
`endif
      chk("ovf_flag", ovf1, 1);
      ordy[1] = 1'b1;
      tick();
      ordy[1] = 1'b0;

      // clr mid-frame
      iv[0] = 1'b1; ia[0] = 4'd15; ib[0] = 4'd15;
      tick();
      tick();
      iv[0] = 1'b0;
      clr[0] = 1'b1;
      tick();
      clr[0] = 1'b0;
      chk("clr_valid", ov0, 0);
      chk("clr_sum", sum0, 0);
      frame0(0);
      tick();
      tick();
      chk("clr_frame_sum", sum0, 254);
      chk("clr_frame_valid", ov0, 1);
      ordy[0] = 1'b1;
      tick();
      ordy[0] = 1'b0;

      // reset during DRAIN
      frame0(0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", ov0, 0);
      chk("mid_rst_sum", sum0, 0);
      chk("mid_rst_ovf", ovf0, 0);
      chk("mid_rst_ready", rdy0, 0);
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      chk("rel_ready", rdy0, 1);
      tick();
      frame0(0);
      tick();
      tick();
      chk("rst_frame_sum", sum0, 254);
      ordy[0] = 1'b1;
      tick();
      ordy[0] = 1'b0;

      // randomized traffic on both instances
      repeat (600) begin
         for (int k = 0; k < 2; k++) begin
            iv[k]   = ($urandom_range(3, 0) != 0);
            ia[k]   = 4'($urandom);
            ib[k]   = 4'($urandom);
            ordy[k] = 1'($urandom_range(1, 0));
            clr[k]  = ($urandom_range(49, 0) == 0);
         end
         tick();
      end
      for (int k = 0; k < 2; k++) begin
         iv[k] = 1'b0;
         clr[k] = 1'b0;
      end
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
